l2_i_refill_responder: RTL and testbench

//  L2-side responder for L1 instruction-cache refills. Accepts a line read request from
//  the L1_I controller (read_l1_l2 + tag/index), looks it up in a direct-mapped L2 store,
//  and returns the 128-bit line with a one-cycle ready_l2_l1 pulse. On an L2 miss it

---
 rtl/l2_i_refill_responder_pkg.sv | 29 ++
 rtl/l2_i_refill_responder_line_store.sv | 47 ++++
 rtl/l2_i_refill_responder.sv | 146 ++++++++++++++
 tb/tb_l2_i_refill_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_i_refill_responder_pkg.sv
// Shared constants, FSM state encoding and address-split helpers for the
// L2 instruction-refill responder.
package l2_i_refill_responder_pkg;

  localparam int L1_TAG_W   = 54;
  localparam int L1_INDEX_W = 6;
  localparam int LINE_W     = 128;
  localparam int L2_INDEX_W = 8;
  localparam int LA_W       = L1_TAG_W + L1_INDEX_W;
  localparam int L2_TAG_W   = LA_W - L2_INDEX_W;
  localparam int L2_LINES   = 1 << L2_INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MISS_REQ = 3'd2,
    S_RESPOND  = 3'd3,
    S_FLUSH    = 3'd4
  } state_e;

  function automatic logic [L2_INDEX_W-1:0] l2_index(input logic [LA_W-1:0] line_addr);
    return line_addr[L2_INDEX_W-1:0];
  endfunction

  function automatic logic [L2_TAG_W-1:0] l2_tag(input logic [LA_W-1:0] line_addr);
    return line_addr[LA_W-1:L2_INDEX_W];
  endfunction

endpackage

// File: rtl/l2_i_refill_responder_line_store.sv
// Direct-mapped L2 line store: resettable valid bits, tag and data arrays,
// one combinational read port, one write port and a per-index valid clear.
module l2_i_refill_responder_line_store
  import l2_i_refill_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [L2_INDEX_W-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [L2_TAG_W-1:0]   rd_tag_o,
  output logic [LINE_W-1:0]     rd_data_o,
  input  logic                  wr_en_i,
  input  logic [L2_INDEX_W-1:0] wr_idx_i,
  input  logic [L2_TAG_W-1:0]   wr_tag_i,
  input  logic [LINE_W-1:0]     wr_data_i,
  input  logic                  clr_en_i,
  input  logic [L2_INDEX_W-1:0] clr_idx_i
);

  logic [L2_LINES-1:0] valid_q;
  logic [L2_TAG_W-1:0] tag_q  [L2_LINES];
  logic [LINE_W-1:0]   data_q [L2_LINES];

  // Valid bits: cleared on reset or by the flush walk, set on a fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clr_en_i) begin
      valid_q[clr_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid gates their contents.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/l2_i_refill_responder.sv
// L2 responder for L1 instruction refills: lookup, memory fill on miss,
// one-cycle ready pulse back to L1, and a full-cache flush walk.
module l2_i_refill_responder
  import l2_i_refill_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_l1_l2,
  input  logic [L1_TAG_W-1:0]   tag_l1_l2,
  input  logic [L1_INDEX_W-1:0] index_l1_l2,
  output logic                  ready_l2_l1,
  output logic [LINE_W-1:0]     data_l2_l1,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy,
  output logic                  read_l2_mem,
  output logic [LA_W-1:0]       addr_l2_mem,
  input  logic                  ready_mem_l2,
  input  logic [LINE_W-1:0]     data_mem_l2
);

  localparam logic [L2_INDEX_W-1:0] CNT_LAST = '1;

  state_e                  state_q;
  logic [LA_W-1:0]         req_addr_q;
  logic [L2_INDEX_W-1:0]   flush_cnt_q;
  logic                    flush_pend_q;
  logic                    ready_q;
  logic [LINE_W-1:0]       data_q;
  logic                    flush_done_q;
  logic                    busy_q;
  logic                    read_mem_q;
  logic [LA_W-1:0]         addr_mem_q;

  logic                    rd_valid_s;
  logic [L2_TAG_W-1:0]     rd_tag_s;
  logic [LINE_W-1:0]       rd_data_s;
  logic                    hit_s;
  logic                    fill_s;

  assign hit_s  = rd_valid_s && (rd_tag_s == l2_tag(req_addr_q));
  // Memory data is only accepted while a fill is actually outstanding.
  assign fill_s = (state_q == S_MISS_REQ) && ready_mem_l2;

  l2_i_refill_responder_line_store u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (l2_index(req_addr_q)),
    .rd_valid_o (rd_valid_s),
    .rd_tag_o   (rd_tag_s),
    .rd_data_o  (rd_data_s),
    .wr_en_i    (fill_s),
    .wr_idx_i   (l2_index(req_addr_q)),
    .wr_tag_i   (l2_tag(req_addr_q)),
    .wr_data_i  (data_mem_l2),
    .clr_en_i   (state_q == S_FLUSH),
    .clr_idx_i  (flush_cnt_q)
  );

  // Control FSM with all L1/memory-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      flush_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
      ready_q      <= 1'b0;
      data_q       <= '0;
      flush_done_q <= 1'b0;
      busy_q       <= 1'b0;
      read_mem_q   <= 1'b0;
      addr_mem_q   <= '0;
    end else begin
      ready_q      <= 1'b0;
      flush_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush || flush_pend_q) begin
            flush_pend_q <= 1'b0;
            flush_cnt_q  <= '0;
            busy_q       <= 1'b1;
            state_q      <= S_FLUSH;
          end else if (read_l1_l2) begin
            req_addr_q <= {tag_l1_l2, index_l1_l2};
            busy_q     <= 1'b1;
            state_q    <= S_LOOKUP;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_LOOKUP: begin
          flush_pend_q <= flush_pend_q | flush;
          if (hit_s) begin
            data_q  <= rd_data_s;
            ready_q <= 1'b1;
            state_q <= S_RESPOND;
          end else begin
            read_mem_q <= 1'b1;
            addr_mem_q <= req_addr_q;
            state_q    <= S_MISS_REQ;
          end
        end
        S_MISS_REQ: begin
          flush_pend_q <= flush_pend_q | flush;
          if (ready_mem_l2) begin
            read_mem_q <= 1'b0;
            data_q     <= data_mem_l2;
            ready_q    <= 1'b1;
            state_q    <= S_RESPOND;
          end else begin
            read_mem_q <= 1'b1;
          end
        end
        S_RESPOND: begin
          flush_pend_q <= flush_pend_q | flush;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        S_FLUSH: begin
          // A second flush here is deliberately dropped: the walk never restarts.
          flush_cnt_q <= flush_cnt_q + L2_INDEX_W'(1);
          if (flush_cnt_q == CNT_LAST) begin
            flush_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: begin
          read_mem_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_l2_l1 = ready_q;
  assign data_l2_l1  = data_q;
  assign flush_done  = flush_done_q;
  assign busy        = busy_q;
  assign read_l2_mem = read_mem_q;
  assign addr_l2_mem = addr_mem_q;

endmodule

// File: tb/tb_l2_i_refill_responder.sv
// Scoreboard bench for the L2 refill responder: expected lines are queued
// when a request is issued and compared when the ready pulse appears.
module tb_l2_i_refill_responder;
  import l2_i_refill_responder_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  read_l1_l2;
  logic [L1_TAG_W-1:0]   tag_l1_l2;
  logic [L1_INDEX_W-1:0] index_l1_l2;
  logic                  ready_l2_l1;
  logic [LINE_W-1:0]     data_l2_l1;
  logic                  flush;
  logic                  flush_done;
  logic                  busy;
  logic                  read_l2_mem;
  logic [LA_W-1:0]       addr_l2_mem;
  logic                  ready_mem_l2;
  logic [LINE_W-1:0]     data_mem_l2;

  int checks   = 0;
  int failures = 0;
  logic [LINE_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  l2_i_refill_responder dut (
    .clk          (clk),
    .rst          (rst),
    .read_l1_l2   (read_l1_l2),
    .tag_l1_l2    (tag_l1_l2),
    .index_l1_l2  (index_l1_l2),
    .ready_l2_l1  (ready_l2_l1),
    .data_l2_l1   (data_l2_l1),
    .flush        (flush),
    .flush_done   (flush_done),
    .busy         (busy),
    .read_l2_mem  (read_l2_mem),
    .addr_l2_mem  (addr_l2_mem),
    .ready_mem_l2 (ready_mem_l2),
    .data_mem_l2  (data_mem_l2)
  );

  // L1 + memory agent: issues one request, answers the memory read after
  // mdelay cycles, optionally pulses flush when the memory read first appears.
  task automatic run_req(input logic [L1_TAG_W-1:0] t, input logic [L1_INDEX_W-1:0] ix,
                         input logic [LINE_W-1:0] mdata, input int mdelay, input bit flush_at_mem,
                         output bit saw_mem, output logic [LA_W-1:0] maddr, output int lat,
                         output logic [LINE_W-1:0] got, output bit tmo);
    int wc;
    wc = 0; saw_mem = 1'b0; maddr = '0; lat = 0; got = '0; tmo = 1'b1;
    @(negedge clk);
    read_l1_l2 = 1'b1; tag_l1_l2 = t; index_l1_l2 = ix;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      lat++;
      flush = 1'b0;
      ready_mem_l2 = 1'b0;
      if (ready_l2_l1) begin
        got = data_l2_l1;
        tmo = 1'b0;
        break;
      end
      if (read_l2_mem) begin
        if (!saw_mem) begin
          saw_mem = 1'b1;
          maddr = addr_l2_mem;
          flush = flush_at_mem;
        end
        if (wc == mdelay) begin
          ready_mem_l2 = 1'b1;
          data_mem_l2 = mdata;
        end
        wc++;
      end
    end
    read_l1_l2 = 1'b0; ready_mem_l2 = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; read_l1_l2 = 1'b0; tag_l1_l2 = '0; index_l1_l2 = '0;
    flush = 1'b0; ready_mem_l2 = 1'b0; data_mem_l2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready_l2_l1, busy, read_l2_mem, flush_done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {ready_l2_l1, busy, read_l2_mem, flush_done});
    end
    checks++;
    if (data_l2_l1 !== 128'd0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", data_l2_l1);
    end
    checks++;
    if (addr_l2_mem !== 60'd0) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=0", addr_l2_mem);
    end
  endtask

  task automatic test_cold_miss();
    bit sm, to; logic [LA_W-1:0] ma; int lat; logic [LINE_W-1:0] got, e;
    exp_q.push_back({16{8'hA5}});
    run_req(54'h1, 6'h05, {16{8'hA5}}, 3, 1'b0, sm, ma, lat, got, to);
    e = exp_q.pop_front();
    checks++;
    if (to || !sm) begin failures++; $display("FAIL cold_miss_mem timeout=%0d saw_mem=%0d exp 0/1", to, sm); end
    checks++;
    if (ma !== 60'h45) begin failures++; $display("FAIL cold_miss_addr got=%h exp=45", ma); end
    checks++;
    if (lat != 6) begin failures++; $display("FAIL cold_miss_latency got=%0d exp=6", lat); end
    checks++;
    if (got !== e) begin failures++; $display("FAIL cold_miss_data got=%h exp=%h", got, e); end
    @(negedge clk);
    checks++;
    if (ready_l2_l1 !== 1'b0) begin failures++; $display("FAIL ready_pulse_width got=%b exp=0", ready_l2_l1); end
  endtask

  task automatic test_hit();
    bit sm, to; logic [LA_W-1:0] ma; int lat; logic [LINE_W-1:0] got, e;
    exp_q.push_back({16{8'hA5}});
    run_req(54'h1, 6'h05, 128'd0, 0, 1'b0, sm, ma, lat, got, to);
    e = exp_q.pop_front();
    checks++;
    if (to || sm) begin failures++; $display("FAIL hit_no_mem timeout=%0d saw_mem=%0d exp 0/0", to, sm); end
    checks++;
    if (lat != 2) begin failures++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    checks++;
    if (got !== e) begin failures++; $display("FAIL hit_data got=%h exp=%h", got, e); end
  endtask

  task automatic test_conflict();
    bit sm, to; logic [LA_W-1:0] ma; int lat; logic [LINE_W-1:0] got, e;
    exp_q.push_back({16{8'h3C}});
    run_req(54'h5, 6'h05, {16{8'h3C}}, 1, 1'b0, sm, ma, lat, got, to);
    e = exp_q.pop_front();
    checks++;
    if (to || !sm || ma !== 60'h145) begin
      failures++; $display("FAIL conflict_miss timeout=%0d saw_mem=%0d addr=%h exp 0/1/145", to, sm, ma);
    end
    checks++;
    if (lat != 4 || got !== e) begin failures++; $display("FAIL conflict_data lat=%0d got=%h exp lat=4 data=%h", lat, got, e); end
    exp_q.push_back({16{8'h5A}});
    run_req(54'h1, 6'h05, {16{8'h5A}}, 0, 1'b0, sm, ma, lat, got, to);
    e = exp_q.pop_front();
    checks++;
    if (to || !sm || ma !== 60'h45) begin
      failures++; $display("FAIL evicted_miss timeout=%0d saw_mem=%0d addr=%h exp 0/1/45", to, sm, ma);
    end
    checks++;
    if (lat != 3 || got !== e) begin failures++; $display("FAIL evicted_data lat=%0d got=%h exp lat=3 data=%h", lat, got, e); end
  endtask

  task automatic test_flush();
    bit sm, to; logic [LA_W-1:0] ma; int lat, k; logic [LINE_W-1:0] got, e;
    run_req(54'h2, 6'h10, {16{8'h77}}, 2, 1'b0, sm, ma, lat, got, to);
    exp_q.push_back({16{8'h77}});
    run_req(54'h2, 6'h10, 128'd0, 0, 1'b0, sm, ma, lat, got, to);
    e = exp_q.pop_front();
    checks++;
    if (to || sm || got !== e) begin failures++; $display("FAIL prefl_hit saw_mem=%0d got=%h exp 0/%h", sm, got, e); end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy got=%b exp=1", busy); end
    k = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (flush_done) begin k = c; break; end
    end
    checks++;
    if (k != 256) begin failures++; $display("FAIL flush_duration got=%0d exp=256", k); end
    @(negedge clk);
    checks++;
    if (flush_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_done_pulse done=%b busy=%b exp 0/0", flush_done, busy); end
    exp_q.push_back({16{8'h88}});
    run_req(54'h2, 6'h10, {16{8'h88}}, 0, 1'b0, sm, ma, lat, got, to);
    e = exp_q.pop_front();
    checks++;
    if (to || !sm || got !== e) begin failures++; $display("FAIL postfl_miss saw_mem=%0d got=%h exp 1/%h", sm, got, e); end
  endtask

  task automatic test_flush_during_miss();
    bit sm, to, fd; logic [LA_W-1:0] ma; int lat; logic [LINE_W-1:0] got, e;
    exp_q.push_back({16{8'h99}});
    run_req(54'h3, 6'h20, {16{8'h99}}, 2, 1'b1, sm, ma, lat, got, to);
    e = exp_q.pop_front();
    checks++;
    if (to || !sm || got !== e) begin failures++; $display("FAIL flmiss_refill saw_mem=%0d got=%h exp 1/%h", sm, got, e); end
    fd = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (flush_done) begin fd = 1'b1; break; end
    end
    checks++;
    if (!fd) begin failures++; $display("FAIL flmiss_pending_flush got=0 exp=1"); end
    exp_q.push_back({16{8'hAA}});
    run_req(54'h3, 6'h20, {16{8'hAA}}, 0, 1'b0, sm, ma, lat, got, to);
    e = exp_q.pop_front();
    checks++;
    if (to || !sm || got !== e) begin failures++; $display("FAIL flmiss_line_flushed saw_mem=%0d got=%h exp 1/%h", sm, got, e); end
  endtask

  task automatic test_read_with_flush();
    bit fd, seen, early; logic [LINE_W-1:0] got, e;
    fd = 1'b0; seen = 1'b0; early = 1'b0; got = '0;
    exp_q.push_back({16{8'hBB}});
    @(negedge clk);
    flush = 1'b1; read_l1_l2 = 1'b1; tag_l1_l2 = 54'h4; index_l1_l2 = 6'h30;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      flush = 1'b0;
      ready_mem_l2 = 1'b0;
      if (flush_done) fd = 1'b1;
      if (ready_l2_l1) begin got = data_l2_l1; seen = 1'b1; break; end
      if (read_l2_mem) begin
        if (!fd) early = 1'b1;
        ready_mem_l2 = 1'b1;
        data_mem_l2 = {16{8'hBB}};
      end
    end
    read_l1_l2 = 1'b0; ready_mem_l2 = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!seen || !fd || early) begin failures++; $display("FAIL flush_before_read seen=%0d flushed=%0d early=%0d exp 1/1/0", seen, fd, early); end
    checks++;
    if (got !== e) begin failures++; $display("FAIL read_after_flush_data got=%h exp=%h", got, e); end
  endtask

  task automatic test_reset_mid_miss();
    bit sm, to, gm, stray; logic [LA_W-1:0] ma; int lat; logic [LINE_W-1:0] got, e;
    gm = 1'b0; stray = 1'b0;
    @(negedge clk);
    read_l1_l2 = 1'b1; tag_l1_l2 = 54'h6; index_l1_l2 = 6'h11;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (read_l2_mem) begin gm = 1'b1; break; end
    end
    checks++;
    if (!gm) begin failures++; $display("FAIL rstmiss_mem_req got=0 exp=1"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; read_l1_l2 = 1'b0;
    checks++;
    if ({read_l2_mem, ready_l2_l1, busy} !== 3'b000) begin
      failures++; $display("FAIL rstmiss_abandon got=%b exp=000", {read_l2_mem, ready_l2_l1, busy});
    end
    ready_mem_l2 = 1'b1; data_mem_l2 = {16{8'hCC}};
    @(negedge clk);
    ready_mem_l2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (ready_l2_l1 || read_l2_mem) stray = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (stray) begin failures++; $display("FAIL late_mem_ignored got=1 exp=0"); end
    exp_q.push_back({16{8'hDD}});
    run_req(54'h6, 6'h11, {16{8'hDD}}, 1, 1'b0, sm, ma, lat, got, to);
    e = exp_q.pop_front();
    checks++;
    if (to || !sm || ma !== 60'h191 || got !== e) begin
      failures++; $display("FAIL rstmiss_remiss saw_mem=%0d addr=%h got=%h exp 1/191/%h", sm, ma, got, e);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_flush_during_miss();
    test_read_with_flush();
    test_reset_mid_miss();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
